// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Byte-addressed data memory acting as the responder for the core's
//   data-memory port. Reads are combinational; writes commit on the rising
//   clock edge. After reset an internal FSM zero-fills the array (CLEAR).
//   Once the core halts, the FSM walks every word and produces a 32-bit
//   checksum (SCAN -> DONE).
//
// Optional feature macro: DATA_MEM_BOUNDS_CHECK_EN
//   Defined   : out-of-range or wrapping writes are suppressed and set the
//               sticky addr_err flag.
//   Undefined : upper address bits alias and lanes wrap modulo the array
//               size; addr_err is tied low.
//
// Parameters
//   ADDR_BITS     byte-address bits decoded (array = 2^ADDR_BITS bytes, >= 3)
//   CHECKSUM_INIT starting value of the checksum accumulator
//
// Ports
//   clk           system clock, rising edge
//   rst_b         asynchronous active-low reset
//   mem_addr      byte address from the core
//   mem_data_in   write lanes; lane k targets mem_addr+k
//   mem_write_en  write strobe (honoured only in RUN)
//   halted        core halt indication
//   mem_data_out  read lanes; lane k = byte at mem_addr+k
//   ready         high in RUN
//   checksum      sum of all words from the last completed scan
//   dump_done     high while the completed scan result is presented
//   addr_err      sticky bounds error (feature build only)

module data_mem_responder #(
  parameter int unsigned ADDR_BITS     = 12,
  parameter logic [31:0] CHECKSUM_INIT = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [31:0]      mem_addr,
  input  logic [0:3][7:0]  mem_data_in,
  input  logic             mem_write_en,
  input  logic             halted,
  output logic [0:3][7:0]  mem_data_out,
  output logic             ready,
  output logic [31:0]      checksum,
  output logic             dump_done,
  output logic             addr_err
);

  localparam int unsigned IDX_BITS = ADDR_BITS - 2;
  localparam int unsigned BYTES    = 1 << ADDR_BITS;
  // Word count is a power of two, so the last word index is all ones.
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_SCAN,
    S_DONE
  } state_t;

  state_t              state;
  logic [IDX_BITS-1:0] idx;
  logic [31:0]         acc;

  logic [7:0]          mem [BYTES];

  logic [ADDR_BITS-1:0] base_idx;
  logic [ADDR_BITS-1:0] lane_idx [4];
  logic [0:3][7:0]      scan_word;
  logic [31:0]          scan_sum;
  logic                 run_we;

  assign base_idx = mem_addr[ADDR_BITS-1:0];

  // Lane addresses wrap naturally in ADDR_BITS-wide arithmetic.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      lane_idx[k] = base_idx + ADDR_BITS'(k);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      mem_data_out[k] = mem[lane_idx[k]];
    end
  end

  // Word idx as seen by CLEAR/SCAN: byte 4*idx is the most significant.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      scan_word[k] = mem[{idx, 2'(k)}];
    end
  end

  assign scan_sum = acc + 32'(scan_word);

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  logic addr_oob;

  assign addr_oob = (mem_addr[31:ADDR_BITS] != '0) ||
                    (base_idx > ADDR_BITS'(BYTES - 4));
  assign run_we   = (state == S_RUN) && mem_write_en && !addr_oob;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      addr_err <= 1'b0;
    end else if ((state == S_RUN) && mem_write_en && addr_oob) begin
      addr_err <= 1'b1;
    end
  end
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^mem_addr[31:ADDR_BITS];
  assign run_we         = (state == S_RUN) && mem_write_en;
  assign addr_err       = 1'b0;
`endif

  // Array storage has no reset; the CLEAR pass provides the known contents.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      for (int unsigned k = 0; k < 4; k++) begin
        mem[{idx, 2'(k)}] <= '0;
      end
    end else if (run_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        mem[lane_idx[k]] <= mem_data_in[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= S_CLEAR;
      idx       <= '0;
      acc       <= CHECKSUM_INIT;
      ready     <= 1'b0;
      dump_done <= 1'b0;
      checksum  <= CHECKSUM_INIT;
    end else begin
      case (state)
        S_CLEAR: begin
          if (idx == IDX_LAST) begin
            state <= S_RUN;
            idx   <= '0;
            ready <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_RUN: begin
          if (halted) begin
            state <= S_SCAN;
            idx   <= '0;
            acc   <= CHECKSUM_INIT;
            ready <= 1'b0;
          end
        end

        S_SCAN: begin
          if (!halted) begin
            // Abort: the previous checksum is left untouched.
            state     <= S_RUN;
            idx       <= '0;
            ready     <= 1'b1;
            dump_done <= 1'b0;
          end else if (idx == IDX_LAST) begin
            state     <= S_DONE;
            idx       <= '0;
            acc       <= scan_sum;
            checksum  <= scan_sum;
            dump_done <= 1'b1;
          end else begin
            acc <= scan_sum;
            idx <= idx + 1'b1;
          end
        end

        S_DONE: begin
          if (!halted) begin
            state     <= S_RUN;
            ready     <= 1'b1;
            dump_done <= 1'b0;
          end
        end

        default: begin
          state <= S_CLEAR;
          idx   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed, self-checking bench for data_mem_responder with default
//   parameters (ADDR_BITS=12, CHECKSUM_INIT=0). Expected values are hand
//   computed. Honours DATA_MEM_BOUNDS_CHECK_EN for the bounds-related checks.

module tb_data_mem_responder;

  logic            clk;
  logic            rst_b;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in;
  logic            mem_write_en;
  logic            halted;
  logic [0:3][7:0] mem_data_out;
  logic            ready;
  logic [31:0]     checksum;
  logic            dump_done;
  logic            addr_err;

  int tests_run;
  int tests_failed;

  data_mem_responder #(
    .ADDR_BITS     (12),
    .CHECKSUM_INIT (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .halted       (halted),
    .mem_data_out (mem_data_out),
    .ready        (ready),
    .checksum     (checksum),
    .dump_done    (dump_done),
    .addr_err     (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one write at the next negedge, commits it, leaves #1 after posedge.
  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_addr     = addr;
    mem_data_in  = data;
    mem_write_en = 1'b1;
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
  endtask

  // Counts posedges until ready rises (budget 2000); writes to 0x20 midway.
  task automatic wait_clear(output int cycles);
    cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ready) break;
      if (cycles == 100) begin
        mem_addr     = 32'h20;
        mem_data_in  = 32'hAABB_CCDD;
        mem_write_en = 1'b1;
      end
      if (cycles == 105) mem_write_en = 1'b0;
    end
    mem_write_en = 1'b0;
  endtask

  task automatic test_reset;
    int cycles;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", ready); end
    tests_run++;
    if (dump_done !== 1'b0) begin tests_failed++; $display("FAIL reset_dump_done: got %b expected 0", dump_done); end
    tests_run++;
    if (checksum !== 32'h0) begin tests_failed++; $display("FAIL reset_checksum: got %h expected 00000000", checksum); end
    tests_run++;
    if (addr_err !== 1'b0) begin tests_failed++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    @(negedge clk);
    rst_b = 1'b1;
    wait_clear(cycles);
    tests_run++;
    if (cycles !== 1024) begin tests_failed++; $display("FAIL clear_cycles: got %0d expected 1024", cycles); end
    mem_addr = 32'h0; #1;
    tests_run++;
    if (mem_data_out !== 32'h0) begin tests_failed++; $display("FAIL clear_read_0: got %h expected 00000000", mem_data_out); end
    mem_addr = 32'h7FD; #1;
    tests_run++;
    if (mem_data_out !== 32'h0) begin tests_failed++; $display("FAIL clear_read_7fd: got %h expected 00000000", mem_data_out); end
    mem_addr = 32'h20; #1;
    tests_run++;
    if (mem_data_out !== 32'h0) begin tests_failed++; $display("FAIL clear_write_ignored: got %h expected 00000000", mem_data_out); end
  endtask

  task automatic test_read_during_write;
    @(negedge clk);
    mem_addr     = 32'h10;
    mem_data_in  = 32'hDEAD_BEEF;
    mem_write_en = 1'b1;
    #1;
    tests_run++;
    if (mem_data_out !== 32'h0) begin tests_failed++; $display("FAIL rdw_same_cycle: got %h expected 00000000", mem_data_out); end
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
    tests_run++;
    if (mem_data_out !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rdw_next_cycle: got %h expected deadbeef", mem_data_out); end
    mem_addr = 32'h12; #1;
    tests_run++;
    if (mem_data_out !== 32'hBEEF_0000) begin tests_failed++; $display("FAIL unaligned_read_12: got %h expected beef0000", mem_data_out); end
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL run_ready: got %b expected 1", ready); end
  endtask

  task automatic test_wrap;
    tests_run++;
    if (addr_err !== 1'b0) begin tests_failed++; $display("FAIL inbounds_no_err: got %b expected 0", addr_err); end
    write_word(32'hFFE, 32'h1122_3344);
    mem_addr = 32'hFFE; #1;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    tests_run++;
    if (mem_data_out !== 32'h0) begin tests_failed++; $display("FAIL wrap_suppressed: got %h expected 00000000", mem_data_out); end
    tests_run++;
    if (addr_err !== 1'b1) begin tests_failed++; $display("FAIL wrap_addr_err: got %b expected 1", addr_err); end
`else
    tests_run++;
    if (mem_data_out !== 32'h1122_3344) begin tests_failed++; $display("FAIL wrap_read_ffe: got %h expected 11223344", mem_data_out); end
    mem_addr = 32'h0; #1;
    tests_run++;
    if (mem_data_out !== 32'h3344_0000) begin tests_failed++; $display("FAIL wrap_read_000: got %h expected 33440000", mem_data_out); end
    mem_addr = 32'h1000_0FFE; #1;
    tests_run++;
    if (mem_data_out !== 32'h1122_3344) begin tests_failed++; $display("FAIL alias_read: got %h expected 11223344", mem_data_out); end
    tests_run++;
    if (addr_err !== 1'b0) begin tests_failed++; $display("FAIL no_err_when_off: got %b expected 0", addr_err); end
`endif
    write_word(32'h0000_2010, 32'h0102_0304);
    mem_addr = 32'h10; #1;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    tests_run++;
    if (mem_data_out !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL alias_write_suppressed: got %h expected deadbeef", mem_data_out); end
`else
    tests_run++;
    if (mem_data_out !== 32'h0102_0304) begin tests_failed++; $display("FAIL alias_write: got %h expected 01020304", mem_data_out); end
`endif
  endtask

  task automatic test_checksum;
    int cycles;
    // Clean slate apart from the two spec words.
    write_word(32'h10,  32'h0);
    write_word(32'hFFC, 32'h0);
    write_word(32'h0,   32'h0000_0001);
    write_word(32'h4,   32'hFFFF_FFFF);
    @(negedge clk);
    halted = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL scan_ready_low: got %b expected 0", ready); end
    // Write attempted mid-scan must be dropped.
    mem_addr = 32'h40; mem_data_in = 32'hAAAA_AAAA; mem_write_en = 1'b1;
    cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 2) mem_write_en = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
      if (dump_done) break;
    end
    mem_write_en = 1'b0;
    tests_run++;
    if (cycles !== 1024) begin tests_failed++; $display("FAIL scan_cycles: got %0d expected 1024", cycles); end
    tests_run++;
    if (checksum !== 32'h0) begin tests_failed++; $display("FAIL checksum_zero: got %h expected 00000000", checksum); end
    mem_addr = 32'h40; #1;
    tests_run++;
    if (mem_data_out !== 32'h0) begin tests_failed++; $display("FAIL scan_write_dropped: got %h expected 00000000", mem_data_out); end
    @(negedge clk);
    halted = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b1 || dump_done !== 1'b0) begin tests_failed++; $display("FAIL done_to_run: got ready=%b dump_done=%b expected 1 0", ready, dump_done); end

    // Second scan: the write issued with halted is committed before scanning.
    @(negedge clk);
    halted = 1'b1;
    mem_addr = 32'h8; mem_data_in = 32'h1234_5678; mem_write_en = 1'b1;
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
    cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (dump_done) break;
    end
    tests_run++;
    if (cycles !== 1024) begin tests_failed++; $display("FAIL scan2_cycles: got %0d expected 1024", cycles); end
    tests_run++;
    if (checksum !== 32'h1234_5678) begin tests_failed++; $display("FAIL checksum_sum: got %h expected 12345678", checksum); end
    @(negedge clk);
    halted = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (checksum !== 32'h1234_5678 || dump_done !== 1'b0) begin tests_failed++; $display("FAIL checksum_held: got %h dump_done=%b expected 12345678 0", checksum, dump_done); end
  endtask

  task automatic test_abort;
    @(negedge clk);
    halted = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    tests_run++;
    if (dump_done !== 1'b0 || checksum !== 32'h1234_5678) begin tests_failed++; $display("FAIL mid_scan_outputs: got dump_done=%b checksum=%h expected 0 12345678", dump_done, checksum); end
    @(negedge clk);
    halted = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready: got %b expected 1", ready); end
    tests_run++;
    if (checksum !== 32'h1234_5678 || dump_done !== 1'b0) begin tests_failed++; $display("FAIL abort_checksum: got %h dump_done=%b expected 12345678 0", checksum, dump_done); end
  endtask

  task automatic test_reset_mid_scan;
    int cycles;
    @(negedge clk);
    halted = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b0 || dump_done !== 1'b0) begin tests_failed++; $display("FAIL async_reset_flags: got ready=%b dump_done=%b expected 0 0", ready, dump_done); end
    tests_run++;
    if (checksum !== 32'h0) begin tests_failed++; $display("FAIL async_reset_checksum: got %h expected 00000000", checksum); end
    halted = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    wait_clear(cycles);
    tests_run++;
    if (cycles !== 1024) begin tests_failed++; $display("FAIL reclear_cycles: got %0d expected 1024", cycles); end
    mem_addr = 32'h8; #1;
    tests_run++;
    if (mem_data_out !== 32'h0) begin tests_failed++; $display("FAIL reclear_read_8: got %h expected 00000000", mem_data_out); end
    mem_addr = 32'h4; #1;
    tests_run++;
    if (mem_data_out !== 32'h0) begin tests_failed++; $display("FAIL reclear_read_4: got %h expected 00000000", mem_data_out); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_b        = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    halted       = 1'b0;
    test_reset();
    test_read_during_write();
    test_wrap();
    test_checksum();
    test_abort();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
